// File: rtl/mips_mc_control.sv
// Main control FSM of the multi-cycle MIPS processor.
//
// Steps FETCH -> DECODE -> execute states for the latched instruction and drives the ALU
// operation, operand selects and every datapath enable. All outputs are combinational from
// the state register, opcode and funct (plus zero / mem_ready). The illegal flag is sticky
// until reset.
//
// Optional feature: define MEM_WAIT_EN to add the mem_ready handshake. FETCH, MEM_RD and
// MEM_WR then hold, with pc_we/ir_we held low, until mem_ready=1.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode, funct         IR[31:26], IR[5:0]
//   zero                  ALU zero flag (beq)
//   mem_ready             memory handshake (MEM_WAIT_EN only)
//   pc_we, pc_src         PC write enable / source select
//   i_or_d, mem_we        memory address select / memory write
//   ir_we                 IR load
//   reg_we, reg_dst       register file write / destination select
//   mem_to_reg            register write-data select
//   alu_src_a, alu_src_b  ALU operand selects
//   ext_sign              immediate sign (1) / zero (0) extension
//   alu_ctrl              ALU operation
//   illegal               sticky unsupported-instruction flag
//   state                 current state (debug)

`ifndef ALU_ADD
`define ALU_ADD 3'b010
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'b110
`endif
`ifndef ALU_OR
`define ALU_OR 3'b001
`endif
`ifndef ALU_SLT
`define ALU_SLT 3'b111
`endif
`ifndef ALU_LUI
`define ALU_LUI 3'b100
`endif

module mips_mc_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic [2:0] alu_ctrl,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExe    = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9
  } state_e;

  localparam logic [5:0] OpR     = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnJr   = 6'b001000;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic mem_go;
`ifdef MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    i_or_d     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_sign   = 1'b0;
    alu_ctrl   = `ALU_ADD;
    case (state_q)
      StFetch: begin
        alu_src_b = 2'd1;
        ir_we     = mem_go;
        pc_we     = mem_go;
        if (mem_go) state_d = StDecode;
      end
      StDecode: begin
        // Branch target computed speculatively into ALUOut.
        alu_src_b = 2'd3;
        case (opcode)
          OpLw, OpSw:             state_d = StMemAdr;
          OpR:                    state_d = (funct == FnJr) ? StJump : StExe;
          OpOri, OpLui, OpAddiu:  state_d = StExe;
          OpBeq:                  state_d = StBranch;
          OpJ, OpJal:             state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext_sign  = 1'b1;
        state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        i_or_d = 1'b1;
        if (mem_go) state_d = StMemWb;
      end
      StMemWb: begin
        reg_we     = 1'b1;
        mem_to_reg = 2'd1;
        state_d    = StFetch;
      end
      StMemWr: begin
        i_or_d = 1'b1;
        mem_we = 1'b1;
        if (mem_go) state_d = StFetch;
      end
      StExe: begin
        alu_src_a = 1'b1;
        state_d   = StAluWb;
        case (opcode)
          OpR: begin
            case (funct)
              FnAddu:  alu_ctrl = `ALU_ADD;
              FnSubu:  alu_ctrl = `ALU_SUB;
              FnSlt:   alu_ctrl = `ALU_SLT;
              default: begin
                illegal_d = 1'b1;
                state_d   = StFetch;
              end
            endcase
          end
          OpOri: begin
            alu_src_b = 2'd2;
            alu_ctrl  = `ALU_OR;
          end
          OpLui: begin
            alu_src_b = 2'd2;
            alu_ctrl  = `ALU_LUI;
          end
          OpAddiu: begin
            alu_src_b = 2'd2;
            ext_sign  = 1'b1;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StAluWb: begin
        reg_we  = 1'b1;
        reg_dst = (opcode == OpR) ? 2'd1 : 2'd0;
        state_d = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_ctrl  = `ALU_SUB;
        pc_src    = 2'd1;
        pc_we     = zero;
        state_d   = StFetch;
      end
      StJump: begin
        pc_we   = 1'b1;
        pc_src  = (opcode == OpR) ? 2'd3 : 2'd2;
        state_d = StFetch;
        if (opcode == OpJal) begin
          // PC already holds PC+4, which is the link value.
          reg_we     = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= state_e'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed scoreboard bench for mips_mc_control: expected per-cycle output vectors are queued
// as each instruction is issued and popped/compared at every falling clock edge.

module tb_mips_mc_control;

  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_SLT = 3'b111;
  localparam logic [2:0] A_LUI = 3'b100;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       src_a;
    logic [1:0] src_b;
    logic       ext_sign;
    logic [2:0] alu;
    logic       illegal;
  } exp_t;

  logic       clk, rst_n, zero;
  logic [5:0] opcode, funct;
  logic       pc_we, i_or_d, mem_we, ir_we, reg_we, alu_src_a, ext_sign, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
`ifdef MEM_WAIT_EN
  logic       mem_ready;
`endif

  mips_mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
`ifdef MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .i_or_d     (i_or_d),
    .mem_we     (mem_we),
    .ir_we      (ir_we),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_sign   (ext_sign),
    .alu_ctrl   (alu_ctrl),
    .illegal    (illegal),
    .state      (state)
  );

  exp_t obs;
  assign obs = {state, pc_we, pc_src, i_or_d, mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, ext_sign, alu_ctrl, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  q[$];
  string tq[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  logic  ill      = 1'b0;
  exp_t  e;

  function automatic exp_t base(input logic [3:0] st);
    exp_t r;
    r         = '0;
    r.st      = st;
    r.alu     = A_ADD;
    r.illegal = ill;
    return r;
  endfunction

  function automatic exp_t fetch_e();
    exp_t r;
    r       = base(4'd0);
    r.ir_we = 1'b1;
    r.pc_we = 1'b1;
    r.src_b = 2'd1;
    return r;
  endfunction

  function automatic exp_t decode_e();
    exp_t r;
    r       = base(4'd1);
    r.src_b = 2'd3;
    return r;
  endfunction

  task automatic push(input exp_t x, input string t);
    q.push_back(x);
    tq.push_back(t);
  endtask

  task automatic check(input exp_t x, input string t);
    n_assert++;
    assert (obs === x) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, x);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard: queue empty at time %0t", $time);
    end else begin
      check(q.pop_front(), tq.pop_front());
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // FETCH cycle, then present the new instruction, then DECODE.
  task automatic begin_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input string t);
    push(fetch_e(), {t, " fetch"});
    step();
    opcode = op;
    funct  = fn;
    zero   = z;
    push(decode_e(), {t, " decode"});
    step();
  endtask

  task automatic r_type(input logic [5:0] fn, input logic [2:0] alu, input string t);
    exp_t x;
    begin_instr(6'b000000, fn, 1'b0, t);
    x = base(4'd6); x.src_a = 1'b1; x.alu = alu; push(x, {t, " exe"});
    x = base(4'd7); x.reg_we = 1'b1; x.reg_dst = 2'd1; push(x, {t, " alu_wb"});
    run(2);
  endtask

  task automatic i_type(input logic [5:0] op, input logic [2:0] alu, input logic ext,
                        input string t);
    exp_t x;
    begin_instr(op, 6'b000000, 1'b0, t);
    x = base(4'd6); x.src_a = 1'b1; x.src_b = 2'd2; x.ext_sign = ext; x.alu = alu;
    push(x, {t, " exe"});
    x = base(4'd7); x.reg_we = 1'b1; push(x, {t, " alu_wb"});
    run(2);
  endtask

  function automatic exp_t memadr_e();
    exp_t r;
    r = base(4'd2); r.src_a = 1'b1; r.src_b = 2'd2; r.ext_sign = 1'b1;
    return r;
  endfunction

  function automatic exp_t memrd_e();
    exp_t r;
    r = base(4'd3); r.i_or_d = 1'b1;
    return r;
  endfunction

  function automatic exp_t memwb_e();
    exp_t r;
    r = base(4'd4); r.reg_we = 1'b1; r.mem_to_reg = 2'd1;
    return r;
  endfunction

  function automatic exp_t memwr_e();
    exp_t r;
    r = base(4'd5); r.i_or_d = 1'b1; r.mem_we = 1'b1;
    return r;
  endfunction

  task automatic beq(input logic z, input string t);
    exp_t x;
    begin_instr(6'b000100, 6'b000000, z, t);
    x = base(4'd8); x.src_a = 1'b1; x.alu = A_SUB; x.pc_src = 2'd1; x.pc_we = z;
    push(x, {t, " branch"});
    run(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    opcode = 6'd0;
    funct  = 6'd0;
    zero   = 1'b0;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    #3;
    check(fetch_e(), "reset state");
    @(posedge clk);
    #1 rst_n = 1'b1;

    r_type(6'b100001, A_ADD, "addu");
    r_type(6'b100011, A_SUB, "subu");
    r_type(6'b101010, A_SLT, "slt");
    i_type(6'b001101, A_OR, 1'b0, "ori");
    i_type(6'b001111, A_LUI, 1'b0, "lui");
    i_type(6'b001001, A_ADD, 1'b1, "addiu");

    begin_instr(6'b100011, 6'd0, 1'b0, "lw");
    push(memadr_e(), "lw mem_adr");
    push(memrd_e(), "lw mem_rd");
    push(memwb_e(), "lw mem_wb");
    run(3);

    begin_instr(6'b101011, 6'd0, 1'b0, "sw");
    push(memadr_e(), "sw mem_adr");
    push(memwr_e(), "sw mem_wr");
    run(2);

    beq(1'b1, "beq taken");
    beq(1'b0, "beq not taken");

    begin_instr(6'b000010, 6'd0, 1'b0, "j");
    e = base(4'd9); e.pc_we = 1'b1; e.pc_src = 2'd2; push(e, "j jump");
    run(1);

    begin_instr(6'b000011, 6'd0, 1'b0, "jal");
    e = base(4'd9); e.pc_we = 1'b1; e.pc_src = 2'd2; e.reg_we = 1'b1; e.reg_dst = 2'd2;
    e.mem_to_reg = 2'd2; push(e, "jal jump");
    run(1);

    begin_instr(6'b000000, 6'b001000, 1'b0, "jr");
    e = base(4'd9); e.pc_we = 1'b1; e.pc_src = 2'd3; push(e, "jr jump");
    run(1);

`ifdef MEM_WAIT_EN
    // Stall FETCH two cycles, then lw with three wait cycles in MEM_RD.
    mem_ready = 1'b0;
    e = fetch_e(); e.ir_we = 1'b0; e.pc_we = 1'b0;
    push(e, "wait fetch hold 0");
    push(e, "wait fetch hold 1");
    run(2);
    mem_ready = 1'b1;
    #1 check(fetch_e(), "wait fetch fire");
    opcode = 6'b100011;
    funct  = 6'd0;
    push(decode_e(), "wait lw decode");
    push(memadr_e(), "wait lw mem_adr");
    run(2);
    mem_ready = 1'b0;
    push(memrd_e(), "wait mem_rd hold 0");
    push(memrd_e(), "wait mem_rd hold 1");
    push(memrd_e(), "wait mem_rd hold 2");
    run(3);
    mem_ready = 1'b1;
    push(memrd_e(), "wait mem_rd fire");
    push(memwb_e(), "wait lw mem_wb");
    run(2);
`endif

    // Unsupported opcode: DECODE returns to FETCH and the flag sticks.
    begin_instr(6'b111111, 6'd0, 1'b0, "bad opcode");
    ill = 1'b1;
    r_type(6'b100001, A_ADD, "addu after illegal");

    // Reset asserted in the middle of MEM_WR aborts the store at once.
    begin_instr(6'b101011, 6'd0, 1'b0, "sw abort");
    push(memadr_e(), "sw abort mem_adr");
    push(memwr_e(), "sw abort mem_wr");
    run(2);
    #1 rst_n = 1'b0;
    #1 ill = 1'b0;
    check(fetch_e(), "async reset mid mem_wr");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Unsupported R funct: EXE goes straight back to FETCH with no writeback.
    begin_instr(6'b000000, 6'b111111, 1'b0, "bad funct");
    e = base(4'd6); e.src_a = 1'b1; push(e, "bad funct exe");
    run(1);
    ill = 1'b1;
    push(fetch_e(), "bad funct sticky fetch");
    run(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Main control FSM of the multi-cycle MIPS processor, directly upstream of the ALU.
- Decodes the latched instruction's opcode/funct and steps FETCH→DECODE→execute states.
- Drives alu_ctrl, the ALU operand selects and all datapath enables (PC, IR, memory, register file).
- Consumes the ALU zero flag for beq.

Parameters:
- RESET_STATE, 4'd0, state code loaded on reset (FETCH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake (present only with MEM_WAIT_EN)
- pc_we  out  1  PC write enable
- pc_src  out  2  0=ALU result, 1=ALUOut, 2={PC[31:28],IR[25:0],00}, 3=reg A
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_we  out  1  memory write
- ir_we  out  1  IR load
- reg_we  out  1  register file write
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=B, 1=const 4, 2=ext imm, 3=sign-ext imm<<2
- ext_sign  out  1  1=sign-extend imm, 0=zero-extend
- alu_ctrl  out  3  ALU op, encoded with the shared ALU_ADD/SUB/OR/SLT/LUI macros
- illegal  out  1  sticky unsupported-instruction flag
- state  out  4  current state (debug)

Behaviour:
- State register updates on posedge clk; all outputs are combinational from state, opcode and funct (plus zero/mem_ready where noted).
- Reset: state=FETCH, illegal=0.
- Default output values in every state: enables 0, selects 0, ext_sign 0, alu_ctrl=ADD.
- Opcodes: R 000000 (funct addu 100001, subu 100011, slt 101010, jr 001000), ori 001101, lui 001111, addiu 001001, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Per state: outputs asserted → next state:
  - FETCH(0): ir_we, pc_we, pc_src=0, src_a=0, src_b=1, ADD → DECODE.
  - DECODE(1): src_a=0, src_b=3, ADD (branch target into ALUOut) → by opcode:
    - lw/sw → MEM_ADR
    - R (not jr)/ori/lui/addiu → EXE
    - beq → BRANCH
    - j/jal/jr → JUMP
    - anything else → FETCH and set illegal
  - MEM_ADR(2): src_a=1, src_b=2, ext_sign=1, ADD → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD(3): i_or_d=1 → MEM_WB.
  - MEM_WB(4): reg_we, reg_dst=0, mem_to_reg=1 → FETCH.
  - MEM_WR(5): i_or_d=1, mem_we → FETCH.
  - EXE(6): src_a=1 → ALU_WB. By instruction:
    - R: src_b=0; alu_ctrl ADD/SUB/SLT from funct.
    - ori: src_b=2, ext_sign=0, OR.
    - lui: src_b=2, LUI.
    - addiu: src_b=2, ext_sign=1, ADD.
    - Unsupported R funct: set illegal, → FETCH with no writeback.
  - ALU_WB(7): reg_we, mem_to_reg=0, reg_dst=1 (R) or 0 (I) → FETCH.
  - BRANCH(8): src_a=1, src_b=0, SUB, pc_src=1, pc_we=zero → FETCH.
  - JUMP(9): pc_we=1 → FETCH.
    - j: pc_src=2.
    - jal: pc_src=2, reg_we, reg_dst=2, mem_to_reg=2 (PC already holds PC+4).
    - jr: pc_src=3.
- Latency in cycles: R/ori/lui/addiu 4, lw 5, sw 4, beq 3, j/jal/jr 3.
- Codes 10–15 are unreachable; if entered, → FETCH with default outputs.
- Async reset mid-instruction aborts immediately: outputs take FETCH values, so no write completes after reset assertion.
- illegal clears only on reset.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - mem_ready port exists.
  - FETCH, MEM_RD and MEM_WR hold their state, with pc_we and ir_we forced 0, until mem_ready=1.
  - The advance and the enables fire in the mem_ready=1 cycle.
  - mem_we stays asserted while waiting in MEM_WR.
- Undefined: port absent; memory states always complete in one cycle.

Test Plan:
- addu (op 0, funct 100001) after reset → states 0,1,6,7,0; EXE alu_ctrl=ADD; ALU_WB reg_we=1, reg_dst=1.
- lw (100011) → states 0,1,2,3,4,0; MEM_ADR ext_sign=1, src_b=2; MEM_WB mem_to_reg=1, reg_we=1.
- beq (000100) with zero=1 then zero=0 → BRANCH pc_we=1 / 0, pc_src=1, alu_ctrl=SUB; 3 cycles each.
- jal (000011) → JUMP pc_src=2, reg_dst=2, mem_to_reg=2, reg_we=1; jr (funct 001000) → pc_src=3, reg_we=0.
- opcode 111111 → DECODE→FETCH, illegal=1 and stays 1 through a following addu; rst_n low clears it and forces state=0 asynchronously mid-MEM_WR, mem_we drops at once.
- MEM_WAIT_EN: lw with mem_ready low 3 cycles in MEM_RD → state stays 3 for 4 cycles, MEM_WB follows; FETCH waits likewise with ir_we=0 while waiting.
